// File: rtl/t07_spi_tft_master.sv
// t07_spi_tft_master: FIFO-fed SPI master that frames address/data writes to an RA8875 TFT controller.
module t07_spi_tft_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int INTERLEAVE = 1,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_GAP     = 2,
  parameter bit CPOL       = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     full_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     ovf_o,
  output logic [ADDR_W+DATA_W-1:0] rx_data_o,
  output logic                     cs_n_o,
  output logic                     sclk_o,
  output logic                     mosi_o,
  input  logic                     miso_i
);
  localparam int F = ADDR_W + DATA_W;
  localparam int BW = $clog2(F + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DMAX = CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP;
  localparam int DW = $clog2(DMAX + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(CS_GAP - 1);
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
  state_t state_q, state_d;
  logic [F-1:0] frame_w, sh_q, sh_d, rx_q, rx_d, rxo_q, rxo_d;
  logic [F-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic ph_q, ph_d, cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic push, pop, last;
  // Interleaved frames alternate address and data bytes, address byte leading.
  if (INTERLEAVE != 0) begin : g_il
    for (genvar g = 0; g < ADDR_W / 8; g++) begin : g_b
      assign frame_w[F-1-16*g -: 8] = addr_i[ADDR_W-1-8*g -: 8];
      assign frame_w[F-9-16*g -: 8] = data_i[DATA_W-1-8*g -: 8];
    end
  end else begin : g_cat
    assign frame_w = {addr_i, data_i};
  end
  assign full_o = cnt_q == CW'(FIFO_DEPTH);
  always_comb begin
    push = wr_en_i && !full_o;
    pop = state_q == IDLE && cnt_q != '0;
    last = div_q == DIV_LAST;
    state_d = state_q;
    div_d = div_q;
    ph_d = ph_q;
    bit_cnt_d = bit_cnt_q;
    sh_d = sh_q;
    rx_d = rx_q;
    rxo_d = rxo_q;
    done_d = 1'b0;
    ovf_d = ovf_q | (wr_en_i & full_o);
    unique case (state_q)
      IDLE: if (pop) begin
        sh_d = mem_q[rp_q];
        bit_cnt_d = BW'(F);
        div_d = '0;
        ph_d = 1'b0;
        state_d = LEAD;
      end
      LEAD: begin
        div_d = last ? '0 : div_q + 1'b1;
        if (last) state_d = SHIFT;
      end
      SHIFT: begin
        if (!ph_q && div_q == '0) rx_d = {rx_q[F-2:0], miso_i};
        div_d = last ? '0 : div_q + 1'b1;
        if (last) begin
          ph_d = !ph_q;
          if (ph_q) begin
            sh_d = sh_q << 1;
            bit_cnt_d = bit_cnt_q - 1'b1;
            if (bit_cnt_q == BW'(1)) state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        div_d = last ? '0 : div_q + 1'b1;
        if (last) begin
          state_d = GAP;
          done_d = 1'b1;
          rxo_d = rx_q;
        end
      end
      GAP: begin
        div_d = div_q == GAP_LAST ? '0 : div_q + 1'b1;
        if (div_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    cs_n_d = state_d == IDLE || state_d == GAP;
    sclk_d = (state_d == SHIFT && !ph_d) ? ~CPOL : CPOL;
    mosi_d = sh_d[F-1];
    busy_d = cnt_d != '0 || state_d != IDLE;
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= frame_w;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      ph_q <= 1'b0;
      bit_cnt_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
      rxo_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      cs_n_q <= 1'b1;
      sclk_q <= CPOL;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      ph_q <= ph_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
      rxo_q <= rxo_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o = ovf_q;
  assign rx_data_o = rxo_q;
  assign cs_n_o = cs_n_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
endmodule

// File: tb/tb_t07_spi_tft_master.sv
// tb_t07_spi_tft_master: vector table, burst/overflow/reset sequences and random frames on two configurations.
module tb_t07_spi_tft_master;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, errors = 0;
  logic wr_a = 1'b0, full_a, busy_a, done_a, ovf_a, cs_a, sclk_a, mosi_a;
  logic [31:0] addr_a = '0, data_a = '0;
  logic [63:0] rx_a;
  t07_spi_tft_master #(.CLK_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en_i(wr_a), .addr_i(addr_a), .data_i(data_a),
    .full_o(full_a), .busy_o(busy_a), .done_o(done_a), .ovf_o(ovf_a), .rx_data_o(rx_a),
    .cs_n_o(cs_a), .sclk_o(sclk_a), .mosi_o(mosi_a), .miso_i(mosi_a));
  logic wr_b = 1'b0, full_b, busy_b, done_b, ovf_b, cs_b, sclk_b, mosi_b;
  logic [7:0] addr_b = '0, data_b = '0;
  logic [15:0] rx_b;
  t07_spi_tft_master #(.ADDR_W(8), .DATA_W(8), .INTERLEAVE(0), .CLK_DIV(3), .CPOL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .wr_en_i(wr_b), .addr_i(addr_b), .data_i(data_b),
    .full_o(full_b), .busy_o(busy_b), .done_o(done_b), .ovf_o(ovf_b), .rx_data_o(rx_b),
    .cs_n_o(cs_b), .sclk_o(sclk_b), .mosi_o(mosi_b), .miso_i(mosi_b));
  // Bus monitors: rebuild each frame from MOSI at SCLK active edges
  bit in_a = 0, in_b = 0;
  logic ps_a = 1'b0, ps_b = 1'b1;
  int low_a, edg_a, ndone_a = 0, nfall_a = 0, low_b, edg_b, ndone_b = 0, run_b = 0, rmin_b = 999, rmax_b = 0;
  logic [63:0] bits_a;
  logic [15:0] bits_b;
  logic [63:0] fr_a[$], rxq_a[$], exp_a[$];
  int edq_a[$], lowq_a[$], dcyc_a[$];
  logic [15:0] fr_b[$], rxq_b[$];
  int edq_b[$], lowq_b[$];
  always @(negedge clk) begin
    if (rst) in_a = 0;
    else begin
      if (!cs_a) begin
        if (!in_a) begin in_a = 1; low_a = 0; edg_a = 0; bits_a = '0; nfall_a++; end
        low_a++;
        if (sclk_a && !ps_a) begin bits_a = {bits_a[62:0], mosi_a}; edg_a++; end
      end else if (in_a) begin
        in_a = 0; fr_a.push_back(bits_a); edq_a.push_back(edg_a); lowq_a.push_back(low_a);
      end
      if (done_a) begin ndone_a++; dcyc_a.push_back(cyc); rxq_a.push_back(rx_a); end
    end
    ps_a = sclk_a;
  end
  always @(negedge clk) begin
    if (rst) in_b = 0;
    else begin
      if (!cs_b) begin
        if (!in_b) begin in_b = 1; low_b = 0; edg_b = 0; bits_b = '0; end
        low_b++;
        if (!sclk_b && ps_b) begin bits_b = {bits_b[14:0], mosi_b}; edg_b++; end
        if (!sclk_b) run_b++;
        else if (run_b > 0) begin
          rmin_b = run_b < rmin_b ? run_b : rmin_b; rmax_b = run_b > rmax_b ? run_b : rmax_b; run_b = 0;
        end
      end else if (in_b) begin
        in_b = 0; fr_b.push_back(bits_b); edq_b.push_back(edg_b); lowq_b.push_back(low_b);
      end
      if (done_b) begin ndone_b++; rxq_b.push_back(rx_b); end
    end
    ps_b = sclk_b;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got %0h want %0h", nm, act, exp); end
  endtask
  task automatic step();
    @(posedge clk); #2;
  endtask
  task automatic push_a(input logic [31:0] a, input logic [31:0] d);
    wr_a = 1'b1; addr_a = a; data_a = d; step(); wr_a = 1'b0;
  endtask
  task automatic push_b(input logic [7:0] a, input logic [7:0] d);
    wr_b = 1'b1; addr_b = a; data_b = d; step(); wr_b = 1'b0;
  endtask
  task automatic wait_a(input int n, input int budget);
    int k = 0;
    while (ndone_a < n && k < budget) begin step(); k++; end
    chk("done_count_a", 64'(ndone_a), 64'(n));
  endtask
  task automatic wait_b(input int n, input int budget);
    int k = 0;
    while (ndone_b < n && k < budget) begin step(); k++; end
    chk("done_count_b", 64'(ndone_b), 64'(n));
  endtask
  // Interleave model: a3 d3 a2 d2 a1 d1 a0 d0
  function automatic logic [63:0] il(input logic [31:0] a, input logic [31:0] d);
    logic [63:0] f = '0;
    for (int i = 3; i >= 0; i--) f = {f[47:0], a[8*i +: 8], d[8*i +: 8]};
    return f;
  endfunction
  task automatic check_frames_a(input int n);
    for (int i = 0; i < n; i++) begin
      if (fr_a.size() == 0 || exp_a.size() == 0 || rxq_a.size() == 0) begin
        chk("frame_present_a", 64'(fr_a.size()), 64'(exp_a.size() + 1));
        return;
      end
      begin
        logic [63:0] e = exp_a.pop_front();
        chk("mosi_frame_a", fr_a.pop_front(), e);
        chk("sclk_edges_a", 64'(edq_a.pop_front()), 64);
        chk("cs_low_a", 64'(lowq_a.pop_front()), 130);
        chk("rx_loop_a", rxq_a.pop_front(), e);
      end
    end
  endtask
  task automatic frame_b(input logic [7:0] a, input logic [7:0] d);
    rmin_b = 999; rmax_b = 0; run_b = 0;
    push_b(a, d);
    wait_b(ndone_b + 1, 500);
    if (fr_b.size() == 0 || rxq_b.size() == 0) chk("frame_present_b", 0, 1);
    else begin
      chk("mosi_frame_b", 64'(fr_b.pop_front()), 64'({a, d}));
      chk("sclk_edges_b", 64'(edq_b.pop_front()), 16);
      chk("cs_low_b", 64'(lowq_b.pop_front()), 102);
      chk("rx_loop_b", 64'(rxq_b.pop_front()), 64'({a, d}));
      chk("half_min_b", 64'(rmin_b), 3);
      chk("half_max_b", 64'(rmax_b), 3);
    end
    repeat (3) step();
    chk("sclk_idle_hi_b", 64'(sclk_b), 1);
    chk("cs_idle_b", 64'(cs_b), 1);
  endtask
  typedef struct {logic [31:0] a; logic [31:0] d; logic [63:0] f;} vec_t;
  initial begin
    vec_t tv[6];
    int nd = 0, base, k, p;
    logic [31:0] ra, rd;
    tv[0] = '{32'h11223344, 32'hAABBCCDD, 64'h11AA22BB33CC44DD};
    tv[1] = '{32'hDEADBEEF, 32'h01234567, 64'hDE01AD23BE45EF67};
    tv[2] = '{32'h00000000, 32'h00000000, 64'h0000000000000000};
    tv[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    tv[4] = '{32'h80000000, 32'h00000001, 64'h8000000000000001};
    tv[5] = '{32'h000000FF, 32'hFF000000, 64'h00FF00000000FF00};
    repeat (3) step();
    chk("rst_cs_a", 64'(cs_a), 1);
    chk("rst_sclk_a", 64'(sclk_a), 0);
    chk("rst_mosi_a", 64'(mosi_a), 0);
    chk("rst_busy_a", 64'(busy_a), 0);
    chk("rst_done_a", 64'(done_a), 0);
    chk("rst_ovf_a", 64'(ovf_a), 0);
    chk("rst_full_a", 64'(full_a), 0);
    chk("rst_rx_a", rx_a, 0);
    chk("rst_cs_b", 64'(cs_b), 1);
    chk("rst_sclk_b", 64'(sclk_b), 1);
    rst = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      exp_a.push_back(tv[i].f);
      push_a(tv[i].a, tv[i].d);
      chk("busy_after_push_a", 64'(busy_a), 1);
      nd++;
      wait_a(nd, 400);
      check_frames_a(1);
      repeat (4) step();
      chk("busy_idle_a", 64'(busy_a), 0);
    end
    dcyc_a.delete();
    for (int i = 0; i < 5; i++) begin
      ra = $urandom; rd = $urandom;
      exp_a.push_back(il(ra, rd));
      push_a(ra, rd);
    end
    nd += 5;
    wait_a(nd, 1500);
    chk("burst_ovf_a", 64'(ovf_a), 0);
    check_frames_a(5);
    if (dcyc_a.size() != 5) chk("burst_dones_a", 64'(dcyc_a.size()), 5);
    else for (int i = 1; i < 5; i++) chk("done_spacing_a", 64'(dcyc_a[i] - dcyc_a[i-1]), 133);
    ra = $urandom; rd = $urandom;
    exp_a.push_back(il(ra, rd));
    push_a(ra, rd);
    k = 0;
    while (cs_a && k < 20) begin step(); k++; end
    chk("cs_fell_a", 64'(cs_a), 0);
    for (int j = 0; j < 5; j++) begin
      ra = $urandom; rd = $urandom;
      if (j < 4) exp_a.push_back(il(ra, rd));
      push_a(ra, rd);
      if (j == 2) chk("not_full_yet_a", 64'(full_a), 0);
      if (j == 3) chk("full_after_4_a", 64'(full_a), 1);
      if (j == 4) begin chk("ovf_set_a", 64'(ovf_a), 1); chk("still_full_a", 64'(full_a), 1); end
    end
    nd += 5;
    wait_a(nd, 1500);
    repeat (300) step();
    chk("exactly_5_frames_a", 64'(ndone_a), 64'(nd));
    chk("ovf_sticky_a", 64'(ovf_a), 1);
    check_frames_a(5);
    chk("no_extra_frame_a", 64'(fr_a.size()), 0);
    base = nfall_a; p = 0;
    for (int i = 0; i < 10; i++) begin
      k = 0;
      while (p - (nfall_a - base) >= 2 && k < 1000) begin step(); k++; end
      repeat ($urandom_range(0, 150)) step();
      chk("rand_not_full_a", 64'(full_a), 0);
      ra = $urandom; rd = $urandom;
      exp_a.push_back(il(ra, rd));
      push_a(ra, rd);
      p++;
    end
    nd += 10;
    wait_a(nd, 3000);
    check_frames_a(10);
    for (int i = 0; i < 3; i++) push_a($urandom, $urandom);
    k = 0;
    while (!(in_a && edg_a >= 10) && k < 200) begin step(); k++; end
    chk("reached_shift_a", 64'(edg_a >= 10), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_cs_a", 64'(cs_a), 1);
    chk("mid_rst_sclk_a", 64'(sclk_a), 0);
    chk("mid_rst_busy_a", 64'(busy_a), 0);
    chk("mid_rst_done_a", 64'(done_a), 0);
    chk("mid_rst_ovf_a", 64'(ovf_a), 0);
    chk("mid_rst_full_a", 64'(full_a), 0);
    chk("mid_rst_rx_a", rx_a, 0);
    rst = 1'b0;
    k = nfall_a;
    repeat (200) step();
    chk("no_done_after_rst_a", 64'(ndone_a), 64'(nd));
    chk("fifo_flushed_a", 64'(nfall_a), 64'(k));
    chk("no_partial_frame_a", 64'(fr_a.size()), 0);
    frame_b(8'hA5, 8'h3C);
    for (int i = 0; i < 3; i++) frame_b(8'($urandom), 8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/t07_spi_tft_master.md
Name: t07_spi_tft_master

Overview:
Parametrised SPI master that drives the RA8875 TFT controller from the memory handler. Write requests (address + data) are queued in a small FIFO and serialised as one chip-select-framed transfer each, MSB first. The SCLK rate, frame widths, byte interleaving, idle clock polarity and inter-frame CS gap are configurable. MISO is captured for read-back.

Parameters:
ADDR_W, 32, address field width in bits; multiple of 8.
DATA_W, 32, data field width in bits; multiple of 8.
INTERLEAVE, 1, 1 = byte-interleave address and data, address byte first (requires ADDR_W == DATA_W); 0 = plain concatenation {addr, data}.
CLK_DIV, 2, clk cycles per SCLK half-period; must be >= 1.
FIFO_DEPTH, 4, request queue entries; power of two, >= 2.
CS_GAP, 2, minimum clk cycles cs_n_o stays high between frames; must be >= 1.
CPOL, 0, SCLK idle level; CPHA is fixed at 0.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_en_i  in  1  push request; accepted only when full_o = 0
addr_i  in  ADDR_W  request address
data_i  in  DATA_W  request data
full_o  out  1  FIFO full (combinational from count)
busy_o  out  1  FIFO non-empty or FSM not in IDLE (registered)
done_o  out  1  one-cycle pulse at frame end
ovf_o  out  1  sticky; set on a push attempt while full
rx_data_o  out  ADDR_W+DATA_W  last received frame; updated with done_o
cs_n_o  out  1  chip select, active low (registered)
sclk_o  out  1  serial clock (registered)
mosi_o  out  1  serial data out (registered)
miso_i  in  1  serial data in

Behaviour:
- F = ADDR_W + DATA_W. Frame word:
  - INTERLEAVE = 1: {a[top byte], d[top byte], ..., a[7:0], d[7:0]}.
  - INTERLEAVE = 0: {addr, data}.
- Reset values:
  - cs_n_o = 1, sclk_o = CPOL, mosi_o = 0.
  - busy_o = 0, done_o = 0, ovf_o = 0, rx_data_o = 0, full_o = 0.
  - FIFO is emptied.
- Reset mid-frame:
  - The frame is abandoned; cs_n_o goes high at the next edge.
  - No done_o pulse is issued.
- FIFO push rules:
  - Push occurs when wr_en_i = 1 and full_o = 0.
  - A push while full is dropped and sets ovf_o, even if a pop happens in the same cycle.
  - Simultaneous push and pop in a non-full state keeps the count unchanged.
- FSM states, in order: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE.
- IDLE:
  - cs_n_o = 1, sclk_o = CPOL.
  - If the FIFO is non-empty, pop the head into the shift register, set bit_cnt = F, and go to LEAD in the same cycle.
- LEAD (CLK_DIV cycles):
  - cs_n_o = 0, mosi_o = frame MSB, sclk_o = CPOL.
- SHIFT (per bit):
  - Active phase of CLK_DIV cycles with sclk_o = ~CPOL. miso_i is sampled into the rx shift register on the first cycle of this phase.
  - Then an idle phase of CLK_DIV cycles with sclk_o = CPOL.
  - At the end of the idle phase, shift left and present the next bit on mosi_o; bit_cnt decrements.
  - After bit F's idle phase, go to TRAIL.
- TRAIL (CLK_DIV cycles):
  - cs_n_o = 0, sclk_o = CPOL.
- GAP (CS_GAP cycles):
  - cs_n_o = 1.
  - On entry: done_o pulses and rx_data_o is loaded with the received word.
- Timing:
  - cs_n_o falls one cycle after the pop.
  - Back-to-back frames: cs_n_o fall-to-fall period = CLK_DIV*(2F+2) + CS_GAP + 1 cycles.
  - There are exactly F SCLK active edges per frame.
- Requests arriving during a frame are queued and do not disturb the frame in flight.
- bit_cnt must hold F; use width $clog2(F+1).

Test Plan:
- Single write, defaults with CLK_DIV = 1, addr = 0x11223344, data = 0xAABBCCDD -> MOSI sampled on SCLK rising edges = 0x11AA22BB33CC44DD; 64 edges; one done_o; cs_n_o low for 130 cycles.
- INTERLEAVE = 0, ADDR_W = DATA_W = 8, CLK_DIV = 3, addr = 0xA5, data = 0x3C -> bits 0xA53C; each SCLK half-period is 3 cycles; cs_n_o low for 3*34 = 102 cycles.
- Loopback miso_i = mosi_o, frame 0xDEADBEEF_01234567 -> rx_data_o = 0xDE01AD23BE45EF67 when done_o pulses.
- Burst of 5 pushes on consecutive cycles, FIFO_DEPTH = 4, CLK_DIV = 1 -> 5 frames sent; done_o pulses 263 cycles apart... use 2*130+2+1 = 263 only at CLK_DIV = 2; at CLK_DIV = 1 they are 133 apart; ovf_o stays 0 because the first pop frees a slot.
- 6 pushes while the FSM is busy -> full_o asserts after the 4th queued; the 6th push is dropped; ovf_o = 1 and sticky; exactly 5 frames emitted.
- rst asserted mid-SHIFT -> next edge cs_n_o = 1, sclk_o = CPOL, busy_o = 0, no done_o; CPOL = 1 run shows sclk_o idling high.
